// File: rtl/tft_timing_rx_if.sv
// Parallel RGB stream bundle (hsync/vsync/de/rgb) between a TFT timing source and a receiver.
// Stream has no backpressure: rgb_in is valid on a tft_clk rising edge exactly when tft_de=1,
// and the receiver must accept every such beat (valid-only, implicit ready=1).
interface tft_timing_rx_if;
  logic       hsync;
  logic       vsync;
  logic       tft_de;
  logic [7:0] rgb_in;

  modport master (output hsync, vsync, tft_de, rgb_in);
  modport slave  (input  hsync, vsync, tft_de, rgb_in);
endinterface

// File: rtl/tft_timing_rx.sv
// TFT RGB receiver: measures line/frame timing, locks after LOCK_FRAMES matching frames,
// then forwards pixels with recovered x/y. Exposes FSM state on state_dbg.
module tft_timing_rx #(
  parameter logic [9:0]  H_TOTAL     = 10'd525,
  parameter logic [9:0]  H_VALID     = 10'd480,
  parameter logic [9:0]  V_TOTAL     = 10'd286,
  parameter logic [9:0]  V_VALID     = 10'd272,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic            tft_clk,
  input  logic            sys_rst_n,
  tft_timing_rx_if.slave  tft,
  output logic [7:0]      pix_data,
  output logic [9:0]      pix_x,
  output logic [9:0]      pix_y,
  output logic            pix_valid,
  output logic            frame_start,
  output logic            lock,
  output logic            timing_err,
  output logic [9:0]      h_total_meas,
  output logic [9:0]      h_active_meas,
  output logic [9:0]      v_total_meas,
  output logic [9:0]      v_active_meas,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [2:0] good, good_n, good_inc;
  logic       err_n;

  logic       s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de;
  logic [7:0] s1_rgb;
  logic [9:0] cnt_h, act_x, cnt_v, act_y;
  logic       frame_eval, line_eval;

  logic line_start, fstart, de_fall, cnt_h_max, match;

  assign line_start = s1_hs & ~s2_hs;
  assign fstart     = s1_vs & ~s2_vs;
  assign de_fall    = s2_de & ~s1_de;
  assign cnt_h_max  = (cnt_h == 10'd1023);
  assign match      = (h_total_meas == H_TOTAL) && (h_active_meas == V_VALID - V_VALID + H_VALID) &&
                      (v_total_meas == V_TOTAL) && (v_active_meas == V_VALID);
  assign good_inc   = good + 3'd1;
  assign state_dbg  = state;

  always_ff @(posedge tft_clk) begin
    if (!sys_rst_n) begin
      s1_hs <= 1'b0; s1_vs <= 1'b0; s1_de <= 1'b0; s1_rgb <= 8'd0;
      s2_hs <= 1'b0; s2_vs <= 1'b0; s2_de <= 1'b0;
      cnt_h <= '0; act_x <= '0; cnt_v <= '0; act_y <= '0;
      h_total_meas <= '0; h_active_meas <= '0;
      v_total_meas <= '0; v_active_meas <= '0;
      frame_start <= 1'b0; frame_eval <= 1'b0; line_eval <= 1'b0;
      pix_data <= '0; pix_x <= '0; pix_y <= '0; pix_valid <= 1'b0;
      state <= SEARCH; good <= '0; lock <= 1'b0; timing_err <= 1'b0;
    end else begin
      s1_hs  <= tft.hsync;
      s1_vs  <= tft.vsync;
      s1_de  <= tft.tft_de;
      s1_rgb <= tft.rgb_in;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_de  <= s1_de;

      // A line that never ends parks cnt_h at 1023; that value is also the loss-of-sync flag.
      if (line_start) begin
        cnt_h        <= '0;
        h_total_meas <= cnt_h_max ? 10'd1023 : cnt_h + 10'd1;
      end else if (!cnt_h_max) begin
        cnt_h <= cnt_h + 10'd1;
      end

      if (line_start) begin
        act_x <= '0;
        if (act_x != '0) h_active_meas <= act_x;
      end else if (s1_de && act_x != 10'd1023) begin
        act_x <= act_x + 10'd1;
      end

      // Coincident hsync/vsync edges: the new line is credited to the closing frame only.
      if (fstart) begin
        v_total_meas <= cnt_v + {9'd0, line_start};
        cnt_v        <= '0;
      end else if (line_start) begin
        cnt_v <= cnt_v + 10'd1;
      end

      if (fstart) begin
        v_active_meas <= act_y;
        act_y         <= '0;
      end else if (de_fall) begin
        act_y <= act_y + 10'd1;
      end

      frame_start <= fstart;
      frame_eval  <= fstart;
      line_eval   <= line_start;

      if (s1_de) begin
        pix_data  <= s1_rgb;
        pix_x     <= act_x;
        pix_y     <= act_y;
        pix_valid <= lock;
      end else begin
        pix_valid <= 1'b0;
      end

      state      <= state_n;
      good       <= good_n;
      lock       <= (state_n == LOCKED);
      timing_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good;
    err_n   = 1'b0;
    case (state)
      SEARCH: begin
        // The frame in progress when searching starts is partial, so it is never scored.
        if (frame_eval) begin
          state_n = VERIFY;
          good_n  = '0;
        end
      end
      VERIFY: begin
        if (frame_eval) begin
          if (!match) begin
            good_n = '0;
          end else if (good_inc == 3'(LOCK_FRAMES)) begin
            state_n = LOCKED;
            good_n  = '0;
          end else begin
            good_n = good_inc;
          end
        end
      end
      LOCKED: begin
        if ((frame_eval && !match) || (line_eval && h_total_meas != H_TOTAL) || cnt_h_max) begin
          state_n = SEARCH;
          err_n   = 1'b1;
        end
      end
      default: state_n = SEARCH;
    endcase
    if (cnt_h_max) begin
      state_n = SEARCH;
      good_n  = '0;
    end
  end

endmodule

// File: tb/tb_tft_timing_rx.sv
// Bench for tft_timing_rx on a scaled-down 40x12 raster (24 DE clocks x 8 DE lines) so
// multi-frame lock/loss scenarios fit in a short run.
module tb_tft_timing_rx;
  localparam int HT = 40, HV = 24, VT = 12, VV = 8;
  localparam int HS_W = 4, DE_C0 = 8, VS_L = 2, DE_L0 = 3, RST_C = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tft_timing_rx_if tft();
  logic [7:0] pix_data;
  logic [9:0] pix_x, pix_y, h_total_meas, h_active_meas, v_total_meas, v_active_meas;
  logic       pix_valid, frame_start, lock, timing_err;
  logic [1:0] state_dbg;

  tft_timing_rx #(
    .H_TOTAL(10'(HT)), .H_VALID(10'(HV)), .V_TOTAL(10'(VT)), .V_VALID(10'(VV)), .LOCK_FRAMES(2)
  ) dut (
    .tft_clk(clk), .sys_rst_n(rst_n), .tft(tft),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .frame_start(frame_start), .lock(lock), .timing_err(timing_err),
    .h_total_meas(h_total_meas), .h_active_meas(h_active_meas),
    .v_total_meas(v_total_meas), .v_active_meas(v_active_meas),
    .state_dbg(state_dbg)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {expected output cycle[59:28], y[27:18], x[17:8], data[7:0]}
  logic [59:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int fs_cnt = 0, err_rises = 0, err_cycles = 0;
  int unsigned fs_cyc = 0, lock_rise_cyc = 0, lock_rise_fs = 0;
  logic [9:0] err_h = '0;
  logic prev_lock = 1'b0, prev_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [7:0] pix_val(input int x, input int y);
    return 8'((y * 37 + x * 5 + 'hA5) & 'hFF);
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, "_pix"}, {pix_data, pix_x, pix_y, pix_valid}, 64'd0);
    check({pfx, "_meas"}, {h_total_meas, h_active_meas, v_total_meas, v_active_meas}, 64'd0);
    check({pfx, "_flags"}, {frame_start, lock, timing_err, state_dbg}, 64'd0);
  endtask

  // One frame; exp_upto = number of leading lines whose pixels must come out valid.
  task automatic drive_frame(input int de_lines, input int short_line, input int exp_upto,
                             input int rst_line);
    logic de;
    int   x, y;
    for (int l = 0; l < VT; l++) begin
      int n;
      n = (l == short_line) ? HT - 1 : HT;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        de = (l >= DE_L0) && (l < DE_L0 + de_lines) && (c >= DE_C0) && (c < DE_C0 + HV);
        x = c - DE_C0;
        y = l - DE_L0;
        tft.hsync  = (c < HS_W);
        tft.vsync  = (l < VS_L);
        tft.tft_de = de;
        tft.rgb_in = de ? pix_val(x, y) : 8'h00;
        if (l == rst_line && c == RST_C) rst_n = 1'b0;
        if (l == rst_line && c == RST_C + 1) begin
          rst_n = 1'b1;
          check_reset("mid_rst");
        end
        if (de && l < exp_upto && !(l == rst_line && c >= RST_C - 1))
          exp_q.push_back({32'(cyc + 2), 10'(y), 10'(x), pix_val(x, y)});
      end
    end
  endtask

  always @(negedge clk) begin
    logic [59:0] e;
    if (frame_start === 1'b1) begin
      fs_cnt++;
      fs_cyc = cyc;
    end
    if (lock === 1'b1 && prev_lock !== 1'b1) begin
      lock_rise_cyc = cyc;
      lock_rise_fs  = fs_cyc;
    end
    prev_lock = lock;
    if (timing_err === 1'b1) begin
      err_cycles++;
      if (prev_err !== 1'b1) begin
        err_rises++;
        err_h = h_total_meas;
      end
    end
    prev_err = timing_err;
    while (exp_q.size() > 0 && exp_q[0][59:28] < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL pix_missing: actual=no pixel required=y%0d x%0d at cycle %0d",
               e[27:18], e[17:8], e[59:28]);
    end
    if (pix_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pix_unexpected: actual=y%0d x%0d d%0h required=no pixel",
                 pix_y, pix_x, pix_data);
      end else begin
        e = exp_q.pop_front();
        check("pix", {cyc, pix_y, pix_x, pix_data}, e);
      end
    end
  end

  initial begin
    tft.hsync = 1'b0; tft.vsync = 1'b0; tft.tft_de = 1'b0; tft.rgb_in = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    drive_frame(VV, -1, 0, -1);
    drive_frame(VV, -1, 0, -1);
    drive_frame(VV, -1, VT, -1);
    check("lock_after_3", lock, 1);
    check("h_total", h_total_meas, HT);
    check("h_active", h_active_meas, HV);
    check("v_total", v_total_meas, VT);
    check("v_active", v_active_meas, VV);
    check("fs_count", fs_cnt, 3);
    check("lock_latency", lock_rise_cyc - lock_rise_fs, 1);
    check("no_err_clean", err_rises, 0);

    drive_frame(VV, -1, VT, -1);
    check("last_pix_x", pix_x, HV - 1);
    check("last_pix_y", pix_y, VV - 1);
    check("last_pix_data", pix_data, pix_val(HV - 1, VV - 1));

    drive_frame(VV, 5, 6, -1);
    check("short_err", err_rises, 1);
    check("short_h_meas", err_h, HT - 1);
    check("short_lock", lock, 0);

    drive_frame(VV, -1, 0, -1);
    drive_frame(VV - 1, -1, 0, -1);
    drive_frame(VV, -1, 0, -1);
    check("bad_v_active", v_active_meas, VV - 1);
    check("bad_state", state_dbg, 2'd1);
    check("bad_lock", lock, 0);
    drive_frame(VV, -1, 0, -1);
    check("good_reset_lock", lock, 0);
    drive_frame(VV, -1, VT, -1);
    check("relock_after_bad", lock, 1);

    repeat (1100) @(negedge clk);
    check("stall_lock", lock, 0);
    check("stall_err", err_rises, 2);
    check("stall_h_hold", h_total_meas, HT);
    check("stall_err_h", err_h, HT);
    for (int c = 0; c < HT; c++) begin
      @(negedge clk);
      tft.hsync = (c < HS_W);
    end
    check("h_sat", h_total_meas, 1023);

    drive_frame(VV, -1, 0, -1);
    drive_frame(VV, -1, 0, -1);
    drive_frame(VV, -1, VT, -1);
    drive_frame(VV, -1, 6, 5);
    drive_frame(VV, -1, 0, -1);
    drive_frame(VV, -1, 0, -1);
    check("post_rst_lock2", lock, 0);
    drive_frame(VV, -1, VT, -1);
    check("post_rst_lock3", lock, 1);
    check("post_rst_latency", lock_rise_cyc - lock_rise_fs, 1);
    check("final_err", err_rises, 2);
    check("err_one_cycle", err_cycles, err_rises);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
